uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
Scheduler that shares the single UART transmitter between NUM_REQ byte requesters. It generates the transmitter's clock-enable tick and arbitrates round-robin among pending requesters. It drives the transmitter's din/wr_en handshake and tracks tx_busy to sequence one frame at a time. It sits between the requester fabric and the transmitter, on the same clock as the transmitter.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width presented to transmitter
CLK_DIV, 16, clk cycles per tx_clken pulse (>=2)
LOAD_TMO, 64, max cycles to wait for tx_busy rise after wr_en asserted

Ports:
clk  input  1  single system clock, rising-edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester byte pending; held until req_ready pulse
req_data  input  NUM_REQ*DATA_W  packed bytes, requester i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse
tx_din  output  DATA_W  byte to transmitter
tx_wr_en  output  1  write enable to transmitter
tx_clken  output  1  baud enable tick to transmitter
tx_busy  input  1  transmitter busy
grant_id  output  $clog2(NUM_REQ)  index of current/last granted requester
sched_busy  output  1  high in any state other than IDLE
err_tmo  output  1  sticky load-timeout flag, cleared only by rst

Behaviour:
- Clock/reset: single clock clk; rst synchronous active-high, wins over all other activity, including mid-frame.
- Reset values: req_ready=0, tx_din=0, tx_wr_en=0, tx_clken=0, grant_id=0, sched_busy=0, err_tmo=0, state=IDLE, divider=0, RR pointer=NUM_REQ-1 (requester 0 is checked first after reset).
- Baud divider: free-running counter 0..CLK_DIV-1. It is unaffected by FSM state. tx_clken=1 for exactly the one cycle where the counter equals CLK_DIV-1, otherwise 0. The counter wraps to 0.
- Arbitration: round-robin. Search starts at last_grant+1 modulo NUM_REQ. The first asserted req_valid wins. The pointer updates only on grant.
- FSM states:
  - IDLE: if any req_valid, then on that edge capture req_data[w] into tx_din, grant_id<=w, req_ready<=onehot(w), tx_wr_en<=1, go LOAD. Otherwise stay; outputs hold.
  - LOAD: req_ready is high only on the first LOAD cycle (1-cycle pulse). tx_wr_en stays 1 and tx_din stays stable. A timeout counter starts at 0 and increments each cycle.
    - If tx_busy==1: tx_wr_en<=0, go SEND.
    - Else if the counter reaches LOAD_TMO-1: tx_wr_en<=0, err_tmo<=1, go IDLE. The byte is dropped; the RR pointer has already advanced.
  - SEND: tx_wr_en=0. When tx_busy==0, go GAP.
  - GAP: single cycle, then go IDLE. This guarantees tx_wr_en is low for at least 2 cycles between frames.
- Latency: req_valid seen in IDLE produces req_ready and tx_wr_en on the next cycle. The earliest next grant comes 2 cycles after tx_busy falls.
- Requester rules:
  - Requester holds valid/data until it sees req_ready, then may drop valid on the following edge.
  - Changes to valid/data outside IDLE are ignored.
  - A requester deasserting valid before grant is legal; it is simply not granted.
- Simultaneous events:
  - Multiple valids: exactly one granted per frame, never two req_ready bits set.
  - tx_busy already high on entry to LOAD: the transition to SEND happens on the first LOAD edge.
  - tx_busy and timeout on the same cycle: tx_busy wins, no error.
- sched_busy = (state != IDLE), registered.

Optional Feature:
UART_SCHED_PRIO_EN: when defined, requester 0 has strict priority. If req_valid[0]=1 in IDLE it is granted regardless of the RR pointer, and the pointer is not updated by a requester-0 grant. Requesters 1..NUM_REQ-1 stay round-robin among themselves. When undefined, all requesters are pure round-robin as above.

Test Plan:
- Reset/divider: CLK_DIV=16, rst high 3 cycles then low -> all outputs 0; tx_clken pulses on cycle 15, 31, 47 after reset release, each 1 cycle wide.
- Single request: req_valid=4'b0010, req_data[1]=8'h63, transmitter model raises tx_busy 2 cycles after wr_en -> next cycle req_ready=4'b0010 (1 cycle), tx_din=8'h63, grant_id=1; tx_wr_en falls the cycle after tx_busy rises; sched_busy drops 2 cycles after tx_busy falls.
- Round-robin fairness: all four valid continuously, bytes A0..A3 -> grant order 0,1,2,3,0,1; no requester granted twice before all others; req_ready always one-hot.
- Load timeout: LOAD_TMO=64, tx_busy tied 0, req_valid[2]=1 -> tx_wr_en high exactly 64 cycles then low, err_tmo=1 and stays 1; next grant goes to requester 3 if valid.
- Reset mid-frame: assert rst while in SEND with tx_busy=1 -> next cycle all outputs at reset values, state IDLE; after release requester 0 is granted first.
- With UART_SCHED_PRIO_EN defined: valid on 0 and 2 continuously -> 0 granted every frame, 2 never; drop valid[0] -> 2 granted next frame.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Requester-fabric and transmitter-side signals of the shared UART transmit scheduler.
// slave is the scheduler's view; master is the view of the surrounding fabric/transmitter.
interface uart_tx_sched_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_din;
    logic                      tx_wr_en;
    logic                      tx_clken;
    logic                      tx_busy;
    logic [IDX_W-1:0]          grant_id;
    logic                      sched_busy;
    logic                      err_tmo;

    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_din, tx_wr_en, tx_clken, grant_id, sched_busy, err_tmo
    );

    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_din, tx_wr_en, tx_clken, grant_id, sched_busy, err_tmo
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NUM_REQ requesters: baud tick, round-robin grant, frame sequencing.
// Define UART_SCHED_PRIO_EN to give requester 0 strict priority over the round-robin group.
module uart_tx_sched #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CLK_DIV  = 16,
    parameter int unsigned LOAD_TMO = 64
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_sched_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned TMO_W = $clog2(LOAD_TMO + 1);
    localparam int unsigned SUM_W = IDX_W + 1;
`ifdef UART_SCHED_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        GAP
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic [SUM_W-1:0]  cand_w;
    logic              pick_found;
    logic [DATA_W-1:0] req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    // Free-running baud divider; the tick is registered to line up with the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= '0;
            bus.tx_clken <= 1'b0;
        end else begin
            div_cnt      <= (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
            bus.tx_clken <= (div_cnt == DIV_W'(CLK_DIV - 2));
        end
    end

    // Round-robin search starting one past the last grant; requester 0 may bypass it.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_w     = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand_w = {1'b0, rr_ptr} + SUM_W'(k);
            if (cand_w >= SUM_W'(NUM_REQ)) begin
                cand_w = cand_w - SUM_W'(NUM_REQ);
            end
            cand = IDX_W'(cand_w);
            if (!pick_found && bus.req_valid[cand] && !(PRIO_EN && (cand == '0))) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        if (PRIO_EN && bus.req_valid[0]) begin
            pick_found = 1'b1;
            pick_idx   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= IDX_W'(NUM_REQ - 1);
            tmo_cnt        <= '0;
            bus.req_ready  <= '0;
            bus.tx_din     <= '0;
            bus.tx_wr_en   <= 1'b0;
            bus.grant_id   <= '0;
            bus.sched_busy <= 1'b0;
            bus.err_tmo    <= 1'b0;
        end else begin
            bus.req_ready <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state          <= LOAD;
                        bus.sched_busy <= 1'b1;
                        bus.tx_din     <= req_bytes[pick_idx];
                        bus.grant_id   <= pick_idx;
                        bus.req_ready  <= NUM_REQ'(1) << pick_idx;
                        bus.tx_wr_en   <= 1'b1;
                        tmo_cnt        <= '0;
                        if (!(PRIO_EN && (pick_idx == '0))) begin
                            rr_ptr <= pick_idx;
                        end
                    end
                end
                // tx_busy outranks a timeout that expires on the same edge.
                LOAD: begin
                    if (bus.tx_busy) begin
                        bus.tx_wr_en <= 1'b0;
                        state        <= SEND;
                    end else if (tmo_cnt == TMO_W'(LOAD_TMO - 1)) begin
                        bus.tx_wr_en   <= 1'b0;
                        bus.err_tmo    <= 1'b1;
                        bus.sched_busy <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                SEND: begin
                    if (!bus.tx_busy) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    bus.sched_busy <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    bus.tx_wr_en   <= 1'b0;
                    bus.sched_busy <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
    a_wr_en_load:   assert property (@(posedge clk) disable iff (rst) bus.tx_wr_en == (state == LOAD));
    a_busy_state:   assert property (@(posedge clk) disable iff (rst) bus.sched_busy == (state != IDLE));
endmodule
